flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Parametrised condition-flag unit for the pipelined CPU; successor to the fixed 16-bit Z/V/N flag register.
- Registers Z, V and N from the EX-stage ALU result under a per-opcode update mask.
- Provides a forwarded next-flag view to ID-stage branch resolution, with stall/flush qualification.
- Holds a one-deep shadow copy for save/restore, plus a branch-condition evaluator.

Parameters:
- DATA_W, 16, ALU result width; N is taken from bit DATA_W-1.
- INSTR_W, 16, EX instruction width.
- OPC_W, 4, opcode width.
- NOP_INSTR, 16'h4000, encoding that never updates flags.
- BUBBLE_INSTR, 16'h0000, encoding inserted by reset/flush that never updates flags.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ex_instr  in  INSTR_W  instruction currently in EX.
- ex_opcode  in  OPC_W  opcode of ex_instr.
- ex_flag_en  in  1  decoder says EX instruction is flag-writing.
- ex_stall  in  1  EX held this cycle; no flag commit.
- ex_flush  in  1  EX instruction squashed; no flag commit.
- alu_result  in  DATA_W  EX ALU result.
- alu_ovf  in  1  EX ALU signed overflow.
- snap_save  in  1  copy committed flags into shadow.
- snap_restore  in  1  load flags from shadow.
- br_cond  in  3  ID-stage branch condition code.
- flags_q  out  3  committed flags {Z,V,N}.
- flags_fwd  out  3  flags as seen by an ID instruction this cycle.
- flags_valid  out  1  at least one flag-writing instruction has committed since reset.
- br_taken  out  1  br_cond evaluated on flags_fwd.

Behaviour:
- Reset (async, rst=1): flags_q=3'b000, shadow=3'b000, flags_valid=0. Outputs follow reset immediately, not at the next edge.
- Commit qualifier: upd = ex_flag_en & ~ex_stall & ~ex_flush & (ex_instr!=NOP_INSTR) & (ex_instr!=BUBBLE_INSTR).
- Update mask, taken from the package constant for each opcode:
  - ADD (4'h0), SUB (4'h1): update Z, V, N.
  - Any other flag-enabled opcode: update Z only.
  - Flags outside the mask hold their value.
- Next values:
  - Z_n = (alu_result == 0) over all DATA_W bits.
  - V_n = alu_ovf.
  - N_n = alu_result[DATA_W-1].
- Register update: on posedge clk when upd=1, write the masked flags; flags_valid is set to 1 and stays set until reset.
- Latency: 1 cycle from EX to flags_q.
- Forwarding: flags_fwd = upd ? masked next flags (held bits from flags_q) : flags_q. It is combinational, with zero latency to the branch in ID.
- br_taken is combinational on flags_fwd, decoded as:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 & N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 | (Z=0 & N=0).
  - 101 LE: N=1 | Z=1.
  - 110 OV: V=1.
  - 111 UN: always 1.
- Shadow:
  - snap_save at posedge copies flags_q (pre-update value) into shadow.
  - snap_restore at posedge loads flags_q from shadow; flags_valid is unchanged.
- Priority at the same edge: snap_restore > upd for flags_q; snap_save always captures the old flags_q. If restore and save coincide, flags_q and shadow swap.
- flags_fwd ignores a pending restore; the restore is visible on the next cycle.
- Stall: flags_q holds, and flags_fwd equals flags_q.
- Flush: same as stall for this instruction; the bubble that follows never updates.
- Reset mid-operation: all state clears and any pending update is lost.

Decomposition:
- Package flag_pkg holds:
  - Flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0.
  - Opcode constants OPC_ADD, OPC_SUB.
  - Function flag_mask(opcode) returning 3 bits.
  - Condition-code constants COND_NE…COND_UN.
- One sub-module: flag_cond_eval, a combinational br_cond+flags→taken evaluator that the ID stage reuses elsewhere.

Test Plan:
- Reset then idle: flags_q=000, flags_valid=0; ADD result 16'h0000, ovf=0 → next cycle flags_q=100, flags_valid=1.
- SUB result 16'h8000 with alu_ovf=1 → flags_q=011; then XOR (opcode 4'h2) result 0 → flags_q=111 (V, N held).
- ADD result 0 with ex_instr=16'h4000, or ex_stall=1, or ex_flush=1 → flags_q unchanged, flags_fwd==flags_q.
- Forwarding: flags_q=000, EX ADD result 16'hFFFF, br_cond=011 → same cycle flags_fwd=001, br_taken=1; br_cond=001 → br_taken=0.
- Shadow: flags_q=100, snap_save; then ADD gives 001; snap_restore together with a flag-writing ADD → flags_q=100 (restore wins); save+restore same edge → swap verified.
- Async reset asserted mid-cycle with flags_q=111, shadow=011 → flags_q=000, flags_valid=0 before the next clk edge; all 8 br_cond codes exhaustively checked against the 8 flag combinations.

Source files
------------

// File: rtl/flag_pkg.sv
// flag_pkg: shared definitions for the condition-flag unit.
//   - Flag bit positions inside the {Z,V,N} vector.
//   - Opcodes that update the full flag set.
//   - flag_mask(): per-opcode update mask.
//   - Branch condition codes evaluated by flag_cond_eval.
package flag_pkg;

    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_N = 0;

    localparam int unsigned OPC_ADD = 32'h0;
    localparam int unsigned OPC_SUB = 32'h1;

    typedef enum logic [2:0] {
        COND_NE = 3'b000,
        COND_EQ = 3'b001,
        COND_GT = 3'b010,
        COND_LT = 3'b011,
        COND_GE = 3'b100,
        COND_LE = 3'b101,
        COND_OV = 3'b110,
        COND_UN = 3'b111
    } cond_e;

    // Arithmetic ops write Z/V/N; every other flag-writing op only writes Z.
    function automatic logic [2:0] flag_mask(input int unsigned opc);
        logic [2:0] mask;
        mask = '0;
        mask[FLAG_Z] = 1'b1;
        if (opc == OPC_ADD || opc == OPC_SUB) begin
            mask = '1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// flag_cond_eval: combinational branch-condition evaluator.
// Ports:
//   cond  in  3  branch condition code (cond_e encoding)
//   flags in  3  flag vector {Z,V,N}
//   taken out 1  condition holds for the given flags
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    always_comb begin
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        n = flags[FLAG_N];
        taken = 1'b0;
        case (cond_e'(cond))
            COND_NE: taken = ~z;
            COND_EQ: taken = z;
            COND_GT: taken = ~z & ~n;
            COND_LT: taken = n;
            COND_GE: taken = z | (~z & ~n);
            COND_LE: taken = n | z;
            COND_OV: taken = v;
            COND_UN: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: registered Z/V/N condition flags for the pipelined CPU.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   ex_instr      instruction in EX (NOP/bubble encodings never commit)
//   ex_opcode     opcode of ex_instr, selects the update mask
//   ex_flag_en    EX instruction writes flags
//   ex_stall      EX held: no commit
//   ex_flush      EX squashed: no commit
//   alu_result    EX ALU result (Z from all bits, N from MSB)
//   alu_ovf       EX ALU signed overflow (V)
//   snap_save     copy committed flags into the shadow register
//   snap_restore  load committed flags from the shadow register
//   br_cond       ID-stage branch condition code
//   flags_q       committed flags {Z,V,N}
//   flags_fwd     flags as seen by ID this cycle (EX result forwarded)
//   flags_valid   a flag-writing instruction has committed since reset
//   br_taken      br_cond evaluated on flags_fwd
module flag_unit
    import flag_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned OPC_W = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h4000,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] ex_instr,
    input  logic [OPC_W-1:0]   ex_opcode,
    input  logic               ex_flag_en,
    input  logic               ex_stall,
    input  logic               ex_flush,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_ovf,
    input  logic               snap_save,
    input  logic               snap_restore,
    input  logic [2:0]         br_cond,
    output logic [2:0]         flags_q,
    output logic [2:0]         flags_fwd,
    output logic               flags_valid,
    output logic               br_taken
);

    logic       upd;
    logic [2:0] mask;
    logic [2:0] raw_next;
    logic [2:0] masked_next;
    logic [2:0] shadow;

    always_comb begin
        upd = ex_flag_en & ~ex_stall & ~ex_flush
            & (ex_instr != NOP_INSTR) & (ex_instr != BUBBLE_INSTR);
        mask = flag_mask(32'(ex_opcode));
        raw_next = '0;
        raw_next[FLAG_Z] = (alu_result == '0);
        raw_next[FLAG_V] = alu_ovf;
        raw_next[FLAG_N] = alu_result[DATA_W-1];
        masked_next = (mask & raw_next) | (~mask & flags_q);
        // Forwarding deliberately ignores a pending restore.
        flags_fwd = upd ? masked_next : flags_q;
    end

    // Restore beats a commit; save always sees the pre-edge flags, so
    // save+restore together swaps flags_q and shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q     <= '0;
            shadow      <= '0;
            flags_valid <= 1'b0;
        end else begin
            if (snap_restore) begin
                flags_q <= shadow;
            end else if (upd) begin
                flags_q <= masked_next;
            end
            if (snap_save) begin
                shadow <= flags_q;
            end
            if (upd) begin
                flags_valid <= 1'b1;
            end
        end
    end

    flag_cond_eval u_cond (
        .cond  (br_cond),
        .flags (flags_fwd),
        .taken (br_taken)
    );

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: self-checking bench for flag_unit with a behavioural model,
// directed scenarios and randomized traffic.
module tb_flag_unit;

    logic        clk;
    logic        rst;
    logic [15:0] ex_instr;
    logic [3:0]  ex_opcode;
    logic        ex_flag_en;
    logic        ex_stall;
    logic        ex_flush;
    logic [15:0] alu_result;
    logic        alu_ovf;
    logic        snap_save;
    logic        snap_restore;
    logic [2:0]  br_cond;
    logic [2:0]  flags_q;
    logic [2:0]  flags_fwd;
    logic        flags_valid;
    logic        br_taken;

    int n_cmp = 0;
    int n_err = 0;

    flag_unit #(
        .DATA_W(16),
        .INSTR_W(16),
        .OPC_W(4),
        .NOP_INSTR(16'h4000),
        .BUBBLE_INSTR(16'h0000)
    ) dut (
        .clk(clk), .rst(rst), .ex_instr(ex_instr), .ex_opcode(ex_opcode),
        .ex_flag_en(ex_flag_en), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .alu_result(alu_result), .alu_ovf(alu_ovf), .snap_save(snap_save),
        .snap_restore(snap_restore), .br_cond(br_cond), .flags_q(flags_q),
        .flags_fwd(flags_fwd), .flags_valid(flags_valid), .br_taken(br_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Flags kept as separate booleans; vectors are only built for comparison.
    logic m_z, m_v, m_n;
    logic s_z, s_v, s_n;
    logic m_valid;

    function automatic logic commits();
        return ex_flag_en && !ex_stall && !ex_flush
            && ex_instr != 16'h4000 && ex_instr != 16'h0000;
    endfunction

    // What an ID instruction should see this cycle, as {Z,V,N}.
    function automatic logic [2:0] exp_fwd();
        logic z, v, n;
        z = m_z; v = m_v; n = m_n;
        if (commits()) begin
            z = (alu_result == 16'd0);
            if (ex_opcode == 4'h0 || ex_opcode == 4'h1) begin
                v = alu_ovf;
                n = alu_result[15];
            end
        end
        return {z, v, n};
    endfunction

    function automatic logic exp_taken(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [2:0] nx;
        if (rst) begin
            m_z <= 0; m_v <= 0; m_n <= 0;
            s_z <= 0; s_v <= 0; s_n <= 0;
            m_valid <= 0;
        end else begin
            nx = exp_fwd();
            if (snap_restore) begin
                m_z <= s_z; m_v <= s_v; m_n <= s_n;
            end else begin
                m_z <= nx[2]; m_v <= nx[1]; m_n <= nx[0];
            end
            if (snap_save) begin
                s_z <= m_z; s_v <= m_v; s_n <= m_n;
            end
            if (commits()) m_valid <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("flags_q", 32'(flags_q), 32'({m_z, m_v, m_n}));
            check("flags_valid", 32'(flags_valid), 32'(m_valid));
            check("flags_fwd", 32'(flags_fwd), 32'(exp_fwd()));
            check("br_taken", 32'(br_taken), 32'(exp_taken(br_cond, exp_fwd())));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [15:0] instr, input logic [3:0] opc,
                         input logic en, input logic [15:0] res, input logic ovf);
        ex_instr = instr; ex_opcode = opc; ex_flag_en = en;
        alu_result = res; alu_ovf = ovf;
    endtask

    task automatic idle();
        drive(16'h4000, 4'h0, 1'b0, 16'h0001, 1'b0);
        ex_stall = 0; ex_flush = 0; snap_save = 0; snap_restore = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Establish flags_q = f ({Z,V,N}) using an ADD then a Z-only op.
    task automatic set_flags(input logic [2:0] f);
        drive(16'h1111, 4'h0, 1'b1, f[0] ? 16'h8000 : 16'h0001, f[1]);
        tick();
        drive(16'h2222, 4'h2, 1'b1, f[2] ? 16'h0000 : 16'h0001, 1'b0);
        tick();
        idle();
    endtask

    initial begin
        rst = 0; br_cond = 3'd0;
        idle();
        #2 rst = 1;
        #1;
        check("reset_flags", 32'(flags_q), 32'h0);
        check("reset_valid", 32'(flags_valid), 32'h0);
        tick(); tick();
        rst = 0;
        tick();

        // ADD result 0 -> Z only.
        drive(16'h1234, 4'h0, 1'b1, 16'h0000, 1'b0);
        tick();
        idle();
        check("add_zero", 32'(flags_q), 32'h4);
        check("valid_set", 32'(flags_valid), 32'h1);

        // SUB negative with overflow, then XOR zero keeps V/N.
        drive(16'h1235, 4'h1, 1'b1, 16'h8000, 1'b1);
        tick();
        check("sub_neg_ovf", 32'(flags_q), 32'h3);
        drive(16'h1236, 4'h2, 1'b1, 16'h0000, 1'b0);
        tick();
        idle();
        check("xor_z_only", 32'(flags_q), 32'h7);

        // NOP encoding, stall and flush must not commit.
        drive(16'h4000, 4'h0, 1'b1, 16'h0001, 1'b0);
        #2 check("nop_fwd", 32'(flags_fwd), 32'h7);
        tick();
        check("nop_hold", 32'(flags_q), 32'h7);
        drive(16'h1237, 4'h0, 1'b1, 16'h0001, 1'b0);
        ex_stall = 1;
        #2 check("stall_fwd", 32'(flags_fwd), 32'h7);
        tick();
        check("stall_hold", 32'(flags_q), 32'h7);
        ex_stall = 0; ex_flush = 1;
        #2 check("flush_fwd", 32'(flags_fwd), 32'h7);
        tick();
        check("flush_hold", 32'(flags_q), 32'h7);
        idle();

        // Forwarding from flags_q = 000.
        set_flags(3'b000);
        check("fwd_base", 32'(flags_q), 32'h0);
        drive(16'h1238, 4'h0, 1'b1, 16'hFFFF, 1'b0);
        br_cond = 3'b011;
        #2 check("fwd_val", 32'(flags_fwd), 32'h1);
        check("fwd_lt", 32'(br_taken), 32'h1);
        br_cond = 3'b001;
        #1 check("fwd_eq", 32'(br_taken), 32'h0);
        tick();
        idle();

        // Shadow save / restore / swap.
        set_flags(3'b100);
        snap_save = 1;
        tick();
        snap_save = 0;
        drive(16'h1239, 4'h0, 1'b1, 16'hFFFF, 1'b0);
        tick();
        check("post_save_add", 32'(flags_q), 32'h1);
        drive(16'h123A, 4'h0, 1'b1, 16'h0005, 1'b0);
        snap_restore = 1;
        tick();
        idle();
        check("restore_wins", 32'(flags_q), 32'h4);
        drive(16'h123B, 4'h0, 1'b1, 16'hFFFF, 1'b0);
        tick();
        idle();
        snap_save = 1; snap_restore = 1;
        tick();
        idle();
        check("swap_flags", 32'(flags_q), 32'h4);
        snap_restore = 1;
        tick();
        idle();
        check("swap_shadow", 32'(flags_q), 32'h1);

        // Async reset mid-cycle with flags=111, shadow=011.
        set_flags(3'b011);
        snap_save = 1;
        tick();
        snap_save = 0;
        drive(16'h123C, 4'h2, 1'b1, 16'h0000, 1'b0);
        tick();
        idle();
        check("pre_rst", 32'(flags_q), 32'h7);
        drive(16'h123D, 4'h0, 1'b1, 16'h8000, 1'b1);
        #2 rst = 1;
        #1;
        check("async_flags", 32'(flags_q), 32'h0);
        check("async_valid", 32'(flags_valid), 32'h0);
        tick();
        idle();
        rst = 0;
        snap_restore = 1;
        tick();
        idle();
        check("shadow_cleared", 32'(flags_q), 32'h0);

        // Every condition code against every flag combination.
        for (int f = 0; f < 8; f++) begin
            set_flags(3'(f));
            check("set_flags", 32'(flags_q), 32'(f));
            for (int c = 0; c < 8; c++) begin
                br_cond = 3'(c);
                #1 check("cond_table", 32'(br_taken), 32'(exp_taken(3'(c), 3'(f))));
            end
            tick();
        end

        // Randomized traffic, with occasional mid-cycle resets.
        for (int i = 0; i < 500; i++) begin
            int unsigned r;
            logic [15:0] res;
            r = $urandom_range(0, 7);
            ex_instr = (r == 0) ? 16'h4000 : (r == 1) ? 16'h0000 : 16'($urandom);
            ex_opcode = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom);
            ex_flag_en = ($urandom_range(0, 3) != 0);
            ex_stall = ($urandom_range(0, 4) == 0);
            ex_flush = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 5);
            res = (r == 0) ? 16'h0000 : (r == 1) ? 16'h8000 : (r == 2) ? 16'hFFFF : 16'($urandom);
            alu_result = res;
            alu_ovf = 1'($urandom);
            snap_save = ($urandom_range(0, 5) == 0);
            snap_restore = ($urandom_range(0, 5) == 0);
            br_cond = 3'($urandom);
            if (i % 61 == 40) begin
                #1 rst = 1;
                #1 rst = 0;
            end
            tick();
        end

        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
